// File: rtl/frame_irq_cfg_seq.sv
// AXI4-Lite master that writes a register image into the frame_cnt_irq_gen slave bank.
// Define READBACK_VERIFY_EN to add a read-back-and-compare pass after all writes.
module frame_irq_cfg_seq #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = C_M_AXI_ADDR_WIDTH'(32'h43C0_0000),
    parameter int unsigned C_NUM_REGS = 4,
    parameter int unsigned C_TIMEOUT = 255
) (
    input  logic                                       ACLK,
    input  logic                                       ARESET,
    input  logic                                       start,
    input  logic [C_M_AXI_DATA_WIDTH*C_NUM_REGS-1:0]   cfg_data,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       error,
    output logic [3:0]                                 err_index,
    output logic [1:0]                                 err_code,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]              M_AXI_AWADDR,
    output logic [2:0]                                 M_AXI_AWPROT,
    output logic                                       M_AXI_AWVALID,
    input  logic                                       M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]              M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]            M_AXI_WSTRB,
    output logic                                       M_AXI_WVALID,
    input  logic                                       M_AXI_WREADY,
    input  logic [1:0]                                 M_AXI_BRESP,
    input  logic                                       M_AXI_BVALID,
    output logic                                       M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]              M_AXI_ARADDR,
    output logic [2:0]                                 M_AXI_ARPROT,
    output logic                                       M_AXI_ARVALID,
    input  logic                                       M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]              M_AXI_RDATA,
    input  logic [1:0]                                 M_AXI_RRESP,
    input  logic                                       M_AXI_RVALID,
    output logic                                       M_AXI_RREADY
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam int unsigned TW = $clog2(C_TIMEOUT + 1);
    localparam int unsigned MAX_REGS = 16;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RD, S_DONE, S_ERR} state_t;

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [DW-1:0]       image_q [MAX_REGS];
    logic [DW*MAX_REGS-1:0] cfg_pad;

    logic          load_image, waiting, fail;
    logic [1:0]    fail_code;
    logic          awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic [AW-1:0] awaddr_d, araddr_d;
    logic [DW-1:0] wdata_d;
    logic          busy_d, done_d, error_d;
    logic [3:0]    err_index_d;
    logic [1:0]    err_code_d;
    logic          aw_left, w_left, last;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;
    assign cfg_pad      = (DW*MAX_REGS)'(cfg_data);
    assign last         = (idx_q == 4'(C_NUM_REGS - 1));

`ifndef READBACK_VERIFY_EN
    logic unused_rd;
    assign unused_rd = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

    function automatic logic [AW-1:0] addr_of(input logic [3:0] i);
        return C_BASE_ADDR + AW'({i, 2'b00});
    endfunction

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tmo_d       = '0;
        awvalid_d   = M_AXI_AWVALID;
        wvalid_d    = M_AXI_WVALID;
        bready_d    = M_AXI_BREADY;
        arvalid_d   = M_AXI_ARVALID;
        rready_d    = M_AXI_RREADY;
        awaddr_d    = M_AXI_AWADDR;
        araddr_d    = M_AXI_ARADDR;
        wdata_d     = M_AXI_WDATA;
        busy_d      = busy;
        done_d      = done;
        error_d     = error;
        err_index_d = err_index;
        err_code_d  = err_code;
        load_image  = 1'b0;
        waiting     = 1'b0;
        fail        = 1'b0;
        fail_code   = 2'd0;
        aw_left     = M_AXI_AWVALID & ~M_AXI_AWREADY;
        w_left      = M_AXI_WVALID & ~M_AXI_WREADY;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    load_image = 1'b1;
                    state_d    = S_WR;
                    idx_d      = '0;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    awaddr_d   = addr_of(4'd0);
                    wdata_d    = cfg_pad[DW-1:0];
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                end
            end
            S_WR: begin
                awvalid_d = aw_left;
                wvalid_d  = w_left;
                if (!aw_left && !w_left) begin
                    state_d  = S_WB;
                    bready_d = 1'b1;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_WB: begin
                if (M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    if (M_AXI_BRESP != 2'b00) begin
                        fail      = 1'b1;
                        fail_code = 2'd1;
                    end else if (last) begin
`ifdef READBACK_VERIFY_EN
                        state_d   = S_RA;
                        idx_d     = '0;
                        arvalid_d = 1'b1;
                        araddr_d  = addr_of(4'd0);
`else
                        state_d   = S_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
`endif
                    end else begin
                        state_d   = S_WR;
                        idx_d     = idx_q + 4'd1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = addr_of(idx_q + 4'd1);
                        wdata_d   = image_q[idx_q + 4'd1];
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
`ifdef READBACK_VERIFY_EN
            S_RA: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_RD: begin
                if (M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    if (M_AXI_RRESP != 2'b00) begin
                        fail      = 1'b1;
                        fail_code = 2'd2;
                    end else if (M_AXI_RDATA != image_q[idx_q]) begin
                        fail      = 1'b1;
                        fail_code = 2'd0;
                    end else if (last) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_RA;
                        idx_d     = idx_q + 4'd1;
                        arvalid_d = 1'b1;
                        araddr_d  = addr_of(idx_q + 4'd1);
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
`endif
            default: ;
        endcase

        // Handshake watchdog: counter restarts on every state change.
        if (waiting) begin
            if (tmo_q == TW'(C_TIMEOUT - 1)) begin
                fail      = 1'b1;
                fail_code = 2'd3;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (fail) begin
            state_d     = S_ERR;
            tmo_d       = '0;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            busy_d      = 1'b0;
            error_d     = 1'b1;
            err_index_d = idx_q;
            err_code_d  = fail_code;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            tmo_q         <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_ARADDR  <= '0;
            M_AXI_WDATA   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_index     <= '0;
            err_code      <= '0;
            for (int i = 0; i < MAX_REGS; i++) image_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            M_AXI_AWVALID <= awvalid_d;
            M_AXI_WVALID  <= wvalid_d;
            M_AXI_BREADY  <= bready_d;
            M_AXI_ARVALID <= arvalid_d;
            M_AXI_RREADY  <= rready_d;
            M_AXI_AWADDR  <= awaddr_d;
            M_AXI_ARADDR  <= araddr_d;
            M_AXI_WDATA   <= wdata_d;
            busy          <= busy_d;
            done          <= done_d;
            error         <= error_d;
            err_index     <= err_index_d;
            err_code      <= err_code_d;
            if (load_image) begin
                for (int i = 0; i < MAX_REGS; i++) image_q[i] <= cfg_pad[DW*i +: DW];
            end
        end
    end

endmodule

// File: tb/tb_frame_irq_cfg_seq.sv
// Self-checking bench for frame_irq_cfg_seq: AXI4-Lite slave model plus write/read scoreboard.
// Expectations adapt to whether READBACK_VERIFY_EN is defined.
`timescale 1ns/1ps
module tb_frame_irq_cfg_seq;

    localparam logic [31:0] BASE = 32'h43C0_0000;

    logic         tb_ACLK, ARESET, start;
    logic [127:0] cfg_data;
    logic         busy, done, error;
    logic [3:0]   err_index;
    logic [1:0]   err_code;
    logic [31:0]  M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]   M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]   M_AXI_WSTRB;
    logic         M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]   M_AXI_BRESP, M_AXI_RRESP;
    logic         M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic         M_AXI_RVALID, M_AXI_RREADY;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave knobs and logs
    int  aw_lat, w_lat, ar_lat, bresp_err_idx, rd_bad_idx;
    bit  aw_block;
    int  aw_wait, w_wait, ar_wait, b_cnt, r_cnt;
    bit  b_fire, r_fire;
    logic [31:0] aw_q[$], w_q[$], ar_q[$];
    logic [31:0] mem [16];
    logic [31:0] exp_wa[$], exp_wd[$], exp_ra[$];
    logic        busy_at_start;

    frame_irq_cfg_seq dut (
        .ACLK(tb_ACLK), .ARESET(ARESET), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error), .err_index(err_index), .err_code(err_code),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    // Slave responder: decides READY/VALID at negedge; a beat fires at the next posedge.
    always @(negedge tb_ACLK) begin
        if (ARESET) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_ARREADY = 0;
            M_AXI_RVALID = 0; b_fire = 0; r_fire = 0;
        end else begin
            if (b_fire) begin M_AXI_BVALID = 0; b_fire = 0; end
            if (!M_AXI_BVALID && aw_q.size() > b_cnt && w_q.size() > b_cnt) begin
                M_AXI_BVALID = 1;
                M_AXI_BRESP  = (b_cnt == bresp_err_idx) ? 2'b10 : 2'b00;
                mem[4'((aw_q[b_cnt] - BASE) >> 2)] = w_q[b_cnt];
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin b_fire = 1; b_cnt++; end

            if (r_fire) begin M_AXI_RVALID = 0; r_fire = 0; end
            if (!M_AXI_RVALID && ar_q.size() > r_cnt) begin
                M_AXI_RVALID = 1;
                M_AXI_RRESP  = 2'b00;
                M_AXI_RDATA  = (r_cnt == rd_bad_idx) ? 32'hdead0010 : mem[4'((ar_q[r_cnt] - BASE) >> 2)];
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin r_fire = 1; r_cnt++; end

            M_AXI_AWREADY = 0;
            if (M_AXI_AWVALID && !aw_block) begin
                if (aw_wait >= aw_lat) begin M_AXI_AWREADY = 1; aw_q.push_back(M_AXI_AWADDR); aw_wait = 0; end
                else aw_wait++;
            end
            M_AXI_WREADY = 0;
            if (M_AXI_WVALID) begin
                if (w_wait >= w_lat) begin M_AXI_WREADY = 1; w_q.push_back(M_AXI_WDATA); w_wait = 0; end
                else w_wait++;
            end
            M_AXI_ARREADY = 0;
            if (M_AXI_ARVALID) begin
                if (ar_wait >= ar_lat) begin M_AXI_ARREADY = 1; ar_q.push_back(M_AXI_ARADDR); ar_wait = 0; end
                else ar_wait++;
            end
        end
    end

    task automatic tick();
        @(negedge tb_ACLK);
        #1;
    endtask

    task automatic reset_slave();
        aw_lat = 0; w_lat = 0; ar_lat = 1; aw_block = 0; bresp_err_idx = -1; rd_bad_idx = -1;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_cnt = 0; r_cnt = 0; b_fire = 0; r_fire = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
        aw_q.delete(); w_q.delete(); ar_q.delete();
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    endtask

    // Pulse start with a new image and push the expected bus traffic.
    task automatic kick(input logic [127:0] cfg);
        for (int i = 0; i < 4; i++) begin
            exp_wa.push_back(BASE + 32'(4 * i));
            exp_wd.push_back(cfg[32*i +: 32]);
            exp_ra.push_back(BASE + 32'(4 * i));
        end
        cfg_data = cfg;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_at_start = busy;
    endtask

    task automatic wait_end(output bit ok, output int cyc);
        ok = 0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (done || error) begin ok = 1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        n_checks++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b want 000", {busy, done, error}); end
        n_checks++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin n_fail++; $display("FAIL reset_handshake: got %b want 00000", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}); end
        n_checks++; if ({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA} !== 96'h0) begin n_fail++; $display("FAIL reset_bus: got %h want 0", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA}); end
        n_checks++; if ({err_index, err_code} !== 6'h0) begin n_fail++; $display("FAIL reset_err: got %h want 0", {err_index, err_code}); end
        n_checks++; if ({M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB} !== 10'h00F) begin n_fail++; $display("FAIL reset_const: got %h want 00f", {M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}); end
    endtask

    task automatic test_basic();
        bit ok; int cyc; logic [31:0] e, o;
        reset_slave();
        kick({32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF});
        wait_end(ok, cyc);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_finish: no done/error after %0d cycles", cyc); end
        n_checks++; if (busy_at_start !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b want 1", busy_at_start); end
        n_checks++; if ({done, error, busy} !== 3'b100) begin n_fail++; $display("FAIL basic_status: done/error/busy got %b want 100", {done, error, busy}); end
        n_checks++; if (aw_q.size() != 4 || w_q.size() != 4) begin n_fail++; $display("FAIL basic_beats: aw %0d w %0d want 4 4", aw_q.size(), w_q.size()); end
        while (exp_wa.size() > 0 && aw_q.size() > 0 && w_q.size() > 0) begin
            e = exp_wa.pop_front(); o = aw_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL basic_awaddr: got %h want %h", o, e); end
            e = exp_wd.pop_front(); o = w_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL basic_wdata: got %h want %h", o, e); end
        end
`ifdef READBACK_VERIFY_EN
        n_checks++; if (ar_q.size() != 4) begin n_fail++; $display("FAIL basic_reads: got %0d want 4", ar_q.size()); end
        while (exp_ra.size() > 0 && ar_q.size() > 0) begin
            e = exp_ra.pop_front(); o = ar_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL basic_araddr: got %h want %h", o, e); end
        end
`else
        n_checks++; if (ar_q.size() != 0) begin n_fail++; $display("FAIL basic_no_reads: got %0d want 0", ar_q.size()); end
`endif
        tick();
        n_checks++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL basic_sticky: done/busy got %b want 10", {done, busy}); end
    endtask

    task automatic test_handshake();
        int awl[3] = '{3, 0, 0};
        int wl[3]  = '{0, 2, 0};
        bit ok; int cyc; logic [31:0] e, o;
        for (int k = 0; k < 3; k++) begin
            reset_slave();
            aw_lat = awl[k]; w_lat = wl[k];
            kick({$urandom, $urandom, $urandom, $urandom});
            wait_end(ok, cyc);
            n_checks++; if (!ok || done !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL hs%0d_done: ok %b done %b error %b want 1 1 0", k, ok, done, error); end
            n_checks++; if (aw_q.size() != 4 || w_q.size() != 4) begin n_fail++; $display("FAIL hs%0d_beats: aw %0d w %0d want 4 4", k, aw_q.size(), w_q.size()); end
            while (exp_wd.size() > 0 && aw_q.size() > 0 && w_q.size() > 0) begin
                e = exp_wa.pop_front(); o = aw_q.pop_front();
                n_checks++; if (o !== e) begin n_fail++; $display("FAIL hs%0d_awaddr: got %h want %h", k, o, e); end
                e = exp_wd.pop_front(); o = w_q.pop_front();
                n_checks++; if (o !== e) begin n_fail++; $display("FAIL hs%0d_wdata: got %h want %h", k, o, e); end
            end
        end
    endtask

    task automatic test_write_error();
        bit ok; int cyc;
        reset_slave();
        bresp_err_idx = 2;
        kick({$urandom, $urandom, $urandom, $urandom});
        wait_end(ok, cyc);
        n_checks++; if (!ok || {error, done, busy} !== 3'b100) begin n_fail++; $display("FAIL werr_status: error/done/busy got %b want 100", {error, done, busy}); end
        n_checks++; if (err_index !== 4'd2 || err_code !== 2'd1) begin n_fail++; $display("FAIL werr_code: idx %0d code %0d want 2 1", err_index, err_code); end
        repeat (20) tick();
        n_checks++; if (aw_q.size() != 3 || ar_q.size() != 0) begin n_fail++; $display("FAIL werr_traffic: aw %0d ar %0d want 3 0", aw_q.size(), ar_q.size()); end
        n_checks++; if ({M_AXI_AWVALID, M_AXI_BREADY, M_AXI_ARVALID} !== 3'b000) begin n_fail++; $display("FAIL werr_idle: got %b want 000", {M_AXI_AWVALID, M_AXI_BREADY, M_AXI_ARVALID}); end
    endtask

    task automatic test_readback_mismatch();
        bit ok; int cyc;
        reset_slave();
        rd_bad_idx = 2;
        kick({$urandom, $urandom, $urandom, $urandom});
        wait_end(ok, cyc);
`ifdef READBACK_VERIFY_EN
        n_checks++; if (!ok || {error, done} !== 2'b10) begin n_fail++; $display("FAIL rb_status: error/done got %b want 10", {error, done}); end
        n_checks++; if (err_index !== 4'd2 || err_code !== 2'd0) begin n_fail++; $display("FAIL rb_code: idx %0d code %0d want 2 0", err_index, err_code); end
        n_checks++; if (ar_q.size() != 3 || M_AXI_RREADY !== 1'b0) begin n_fail++; $display("FAIL rb_reads: ar %0d rready %b want 3 0", ar_q.size(), M_AXI_RREADY); end
`else
        n_checks++; if (!ok || {error, done} !== 2'b01) begin n_fail++; $display("FAIL rb_off_status: error/done got %b want 01", {error, done}); end
        n_checks++; if (ar_q.size() != 0) begin n_fail++; $display("FAIL rb_off_reads: got %0d want 0", ar_q.size()); end
`endif
    endtask

    task automatic test_timeout();
        bit ok; int cyc;
        reset_slave();
        aw_block = 1;
        kick({$urandom, $urandom, $urandom, $urandom});
        wait_end(ok, cyc);
        n_checks++; if (!ok || cyc != 255) begin n_fail++; $display("FAIL tmo_cycles: got %0d (ok %b) want 255", cyc, ok); end
        n_checks++; if ({error, busy} !== 2'b10 || err_code !== 2'd3 || err_index !== 4'd0) begin n_fail++; $display("FAIL tmo_code: err/busy %b code %0d idx %0d want 10 3 0", {error, busy}, err_code, err_index); end
        n_checks++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== 3'b000) begin n_fail++; $display("FAIL tmo_valids: got %b want 000", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}); end
        aw_block = 0;
    endtask

    task automatic test_busy_and_reset();
        bit ok; int cyc; logic [127:0] cfg_a; logic [31:0] e, o;
        // Start pulse while register 1 is in flight must not restart the sequence.
        reset_slave();
        aw_lat = 2;
        cfg_a = {$urandom, $urandom, $urandom, $urandom};
        kick(cfg_a);
        for (cyc = 0; cyc < 200 && aw_q.size() < 2; cyc++) tick();
        n_checks++; if (aw_q.size() < 2) begin n_fail++; $display("FAIL busy_reach: aw beats %0d want 2", aw_q.size()); end
        cfg_data = ~cfg_a;
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_hold: got %b want 1", busy); end
        wait_end(ok, cyc);
        n_checks++; if (!ok || done !== 1'b1 || aw_q.size() != 4) begin n_fail++; $display("FAIL busy_done: done %b beats %0d want 1 4", done, aw_q.size()); end
        while (exp_wd.size() > 0 && w_q.size() > 0) begin
            e = exp_wd.pop_front(); o = w_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL busy_wdata: got %h want %h", o, e); end
        end
        // Reset while waiting for BRESP clears everything immediately.
        reset_slave();
        kick({$urandom, $urandom, $urandom, $urandom});
        for (cyc = 0; cyc < 50 && M_AXI_BREADY !== 1'b1; cyc++) tick();
        n_checks++; if (M_AXI_BREADY !== 1'b1) begin n_fail++; $display("FAIL rst_reach_wb: bready %b want 1", M_AXI_BREADY); end
        ARESET = 1'b1;
        #1;
        n_checks++; if ({busy, done, error, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 8'h0) begin n_fail++; $display("FAIL rst_ctrl: got %b want 0", {busy, done, error, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}); end
        n_checks++; if ({M_AXI_AWADDR, M_AXI_WDATA, err_index, err_code} !== 70'h0) begin n_fail++; $display("FAIL rst_bus: got %h want 0", {M_AXI_AWADDR, M_AXI_WDATA, err_index, err_code}); end
        tick(); ARESET = 1'b0; tick();
        // A fresh sequence after reset completes normally.
        reset_slave();
        kick({$urandom, $urandom, $urandom, $urandom});
        wait_end(ok, cyc);
        n_checks++; if (!ok || {done, error} !== 2'b10 || w_q.size() != 4) begin n_fail++; $display("FAIL rst_rerun: done/error %b beats %0d want 10 4", {done, error}, w_q.size()); end
        while (exp_wd.size() > 0 && w_q.size() > 0) begin
            e = exp_wd.pop_front(); o = w_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL rst_wdata: got %h want %h", o, e); end
        end
    endtask

    initial begin
        ARESET = 1'b1;
        start = 1'b0;
        cfg_data = '0;
        reset_slave();
        repeat (3) tick();
        test_reset();
        ARESET = 1'b0;
        tick();
        test_basic();
        test_handshake();
        test_write_error();
        test_readback_mismatch();
        test_timeout();
        test_busy_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
